stepdown_drive_seq: RTL
=======================

# stepdown_drive_seq

Gate-drive sequencer for the step-down loop control: the output end of the loop whose input side qualifies `i0`/`i1`/`i2` against `Tstate` and produces a single turn-on request `o`. This block consumes that request as `req`, drives the high-side and low-side enables with guaranteed dead time and bounded on/off times, and returns `tstate`, which the input qualifier ANDs in to accept a new request. It sits between the loop-control qualifier and the power-stage drivers.

## Interface
Parameters:
- `DEAD_CYC`, default 4: dead-time cycles, both enables low, between any enable transition. Legal range 1..2^CNT_W-1.
- `TON_MIN`, default 8: minimum high-side on cycles.
- `TON_MAX`, default 200: maximum high-side on cycles. Requires TON_MIN ≤ TON_MAX ≤ 2^CNT_W.
- `TOFF_MIN`, default 8: minimum low-side on cycles before a new request is accepted.
- `CNT_W`, default 8: phase counter width.

Ports:
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: qualified turn-on request, driven by the input qualifier's `o`. Level-sensitive.
- `stop` in 1: turn-off request, e.g. peak-current compare. Honoured only after TON_MIN.
- `zc` in 1: inductor zero-cross. Ends the low-side phase.
- `fault` in 1: forces both enables off immediately, as a registered response.
- `hs_en` out 1: high-side enable.
- `ls_en` out 1: low-side enable.
- `tstate` out 1: sequencer ready to accept `req`; drives the qualifier's `Tstate`.
- `maxon` out 1: one-cycle pulse when a high-side phase ends by TON_MAX.
- `CELV`, `CELG`, `SUB` in 1: supply and substrate pins, kept for netlist compatibility. They have no logic function.

## Operation
- Moore FSM with states IDLE, DT_H, HS_ON, DT_L, LS_ON, FAULT.
- A shared counter `cnt` (CNT_W bits) clears to 0 on every state change and otherwise increments. It saturates at all-ones and never wraps.
- Output decode by state:
  - IDLE: hs=0, ls=0, tstate=1.
  - DT_H: all three outputs 0.
  - HS_ON: hs=1, ls=0, tstate=0.
  - DT_L: all three outputs 0.
  - LS_ON: hs=0, ls=1, tstate=1 only when cnt ≥ TOFF_MIN-1, else 0.
  - FAULT: all three outputs 0.
- Transitions, in priority order:
  - fault=1 from any state goes to FAULT.
  - FAULT goes to IDLE on the first cycle with fault=0.
  - IDLE goes to DT_H when req=1.
  - DT_H goes to HS_ON when cnt == DEAD_CYC-1.
  - HS_ON goes to DT_L when cnt == TON_MAX-1, which also pulses `maxon`. It also goes to DT_L when stop=1 and cnt ≥ TON_MIN-1.
  - DT_L goes to LS_ON when cnt == DEAD_CYC-1.
  - LS_ON with cnt ≥ TOFF_MIN-1: req=1 goes to DT_H; otherwise zc=1 goes to IDLE. If both are asserted, req wins.
  - LS_ON with cnt < TOFF_MIN-1: req and zc are ignored. LS_ON persists indefinitely without either.
- `stop` asserted before TON_MIN is ignored; it must still be high at or after cycle TON_MIN to end the phase.
- `hs_en` and `ls_en` are never both 1. Every 0→1 edge on either enable is preceded by at least DEAD_CYC cycles with both low. This invariant holds through fault and recovery: FAULT returns to IDLE, and IDLE always passes through DT_H.
- Reset state is IDLE with cnt=0.

## Timing
- All outputs are registered; inputs are sampled at the rising edge of `clk`.
- Reset values: hs_en=0, ls_en=0, tstate=1, maxon=0.
- Reset mid-operation drops both enables asynchronously, with no dead-time phase.
- req high at edge k in IDLE:
  - DT_H occupies edges k+1..k+DEAD_CYC.
  - hs_en=1 from edge k+1+DEAD_CYC.
  - tstate falls at edge k+1.
- High-side pulse width lies in [TON_MIN, TON_MAX] cycles, except when fault terminates it.
  - With stop held high throughout, the width is exactly TON_MIN.
  - With stop never asserted, the width is exactly TON_MAX.
- When hs_en falls at edge m, ls_en rises at edge m+DEAD_CYC.
- In LS_ON, tstate rises TOFF_MIN-1 cycles after ls_en rises.
- fault sampled high at edge f: both enables and tstate are 0 from edge f+1.
- fault low at edge g: IDLE, with tstate=1, from edge g+1.

## Structure
- Shared package `stepdown_pkg` holds:
  - the state enum `sd_drv_state_t`;
  - the default timing constants (`SD_DEAD_CYC`, `SD_TON_MIN`, `SD_TON_MAX`, `SD_TOFF_MIN`), which the loop-control top also uses.
- One sub-module is natural: `stepdown_phase_cnt`, a saturating counter with a synchronous clear on state change and threshold-compare outputs.
- The FSM and the registered output decode stay in the top module.

## Test plan
- **Basic cycle.** Defaults; pulse req for 1 cycle from IDLE, stop at hs cycle 20, zc 30 cycles into LS_ON. Required:
  - hs_en rises 5 cycles after req and stays high 20 cycles;
  - 4 dead cycles;
  - ls_en high 30 cycles;
  - then IDLE with tstate=1.
- **Min/max on-time.** stop held high: hs_en width = 8. stop never high: width = 200, with a single maxon pulse coincident with hs_en falling.
- **Off-time lockout.** req held high continuously: each ls_en phase lasts exactly 8 cycles, and tstate is low for the first 7 of them.
- **Simultaneous req and zc** in LS_ON after TOFF_MIN: the FSM goes to DT_H, not IDLE.
- **Fault mid-HS_ON** at cnt=50: hs_en=0 on the next edge. After fault clears, the FSM goes to IDLE, and the next req yields the full 4-cycle dead time before hs_en.
- **Reset and invariant.** Assert rst_n low asynchronously mid-LS_ON: ls_en drops without waiting for a clock edge. An assertion checks over 10k random req/stop/zc/fault cycles that hs_en and ls_en are never both high and that every enable rising edge has at least 4 dead cycles before it.

Source files
------------

// File: rtl/stepdown_pkg.sv
// Shared definitions for the step-down loop control: drive-sequencer state
// encoding and the default timing constants used by the loop-control top.
package stepdown_pkg;

  localparam int unsigned SD_CNT_W    = 8;
  localparam int unsigned SD_DEAD_CYC = 4;
  localparam int unsigned SD_TON_MIN  = 8;
  localparam int unsigned SD_TON_MAX  = 200;
  localparam int unsigned SD_TOFF_MIN = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DT_H  = 3'd1,
    ST_HS_ON = 3'd2,
    ST_DT_L  = 3'd3,
    ST_LS_ON = 3'd4,
    ST_FAULT = 3'd5
  } sd_drv_state_t;

endpackage

// File: rtl/stepdown_phase_cnt.sv
// Phase counter for the drive sequencer: saturating up-counter with a
// synchronous clear, plus the threshold compares the FSM needs.
//   clk, rst_n     : clock, async active-low reset
//   clr            : clear to 0 on this edge (state change)
//   dead_done_c    : cnt == DEAD_CYC-1
//   ton_min_ok_c   : cnt >= TON_MIN-1
//   ton_max_hit_c  : cnt == TON_MAX-1
//   toff_ok_c      : cnt >= TOFF_MIN-1
module stepdown_phase_cnt #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEAD_CYC = 4,
  parameter int unsigned TON_MIN  = 8,
  parameter int unsigned TON_MAX  = 200,
  parameter int unsigned TOFF_MIN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic dead_done_c,
  output logic ton_min_ok_c,
  output logic ton_max_hit_c,
  output logic toff_ok_c
);

  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] TON_LO    = CNT_W'(TON_MIN - 1);
  localparam logic [CNT_W-1:0] TON_HI    = CNT_W'(TON_MAX - 1);
  localparam logic [CNT_W-1:0] TOFF_LO   = CNT_W'(TOFF_MIN - 1);

  logic [CNT_W-1:0] cnt;

  // Counts cycles spent in the current state; holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != CNT_SAT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign dead_done_c   = (cnt == DEAD_LAST);
  assign ton_min_ok_c  = (cnt >= TON_LO);
  assign ton_max_hit_c = (cnt == TON_HI);
  assign toff_ok_c     = (cnt >= TOFF_LO);

endmodule

// File: rtl/stepdown_drive_seq.sv
// Gate-drive sequencer for the step-down loop. Turns the qualified request
// into high-side / low-side enables with dead time and bounded on/off times.
//   clk, rst_n        : clock, async active-low reset
//   req               : qualified turn-on request (level)
//   stop              : turn-off request, honoured after TON_MIN
//   zc                : inductor zero-cross, ends the low-side phase
//   fault             : forces both enables off (registered response)
//   hs_en, ls_en      : high-/low-side enables (registered)
//   tstate            : ready to accept req (registered)
//   maxon             : one-cycle pulse, aligned with hs_en falling on TON_MAX
//   CELV, CELG, SUB   : supply/substrate pins, no logic function
module stepdown_drive_seq
  import stepdown_pkg::*;
#(
  parameter int unsigned DEAD_CYC = SD_DEAD_CYC,
  parameter int unsigned TON_MIN  = SD_TON_MIN,
  parameter int unsigned TON_MAX  = SD_TON_MAX,
  parameter int unsigned TOFF_MIN = SD_TOFF_MIN,
  parameter int unsigned CNT_W    = SD_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic stop,
  input  logic zc,
  input  logic fault,
  output logic hs_en,
  output logic ls_en,
  output logic tstate,
  output logic maxon,
  input  logic CELV,
  input  logic CELG,
  input  logic SUB
);

  sd_drv_state_t state;
  sd_drv_state_t state_nxt;

  logic dead_done_c;
  logic ton_min_ok_c;
  logic ton_max_hit_c;
  logic toff_ok_c;

  logic hs_c;
  logic ls_c;
  logic ts_c;
  logic maxon_hit_c;
  logic maxon_q;

  logic unused_supply;
  assign unused_supply = ^{CELV, CELG, SUB};

  stepdown_phase_cnt #(
    .CNT_W    (CNT_W),
    .DEAD_CYC (DEAD_CYC),
    .TON_MIN  (TON_MIN),
    .TON_MAX  (TON_MAX),
    .TOFF_MIN (TOFF_MIN)
  ) u_phase_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (state_nxt != state),
    .dead_done_c   (dead_done_c),
    .ton_min_ok_c  (ton_min_ok_c),
    .ton_max_hit_c (ton_max_hit_c),
    .toff_ok_c     (toff_ok_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; fault overrides every state.
  always_comb begin
    state_nxt   = state;
    maxon_hit_c = 1'b0;
    hs_c        = 1'b0;
    ls_c        = 1'b0;
    ts_c        = 1'b0;

    unique case (state)
      ST_IDLE:  ts_c = 1'b1;
      ST_HS_ON: hs_c = 1'b1;
      ST_LS_ON: begin
        ls_c = 1'b1;
        ts_c = toff_ok_c;
      end
      default: ;
    endcase

    if (fault) begin
      state_nxt = ST_FAULT;
    end else begin
      unique case (state)
        ST_FAULT: state_nxt = ST_IDLE;
        ST_IDLE:  if (req) state_nxt = ST_DT_H;
        ST_DT_H:  if (dead_done_c) state_nxt = ST_HS_ON;
        ST_HS_ON: begin
          if (ton_max_hit_c) begin
            state_nxt   = ST_DT_L;
            maxon_hit_c = 1'b1;
          end else if (stop && ton_min_ok_c) begin
            state_nxt = ST_DT_L;
          end
        end
        ST_DT_L:  if (dead_done_c) state_nxt = ST_LS_ON;
        ST_LS_ON: begin
          // req has priority over zc once the off-time minimum is met.
          if (toff_ok_c) begin
            if (req) begin
              state_nxt = ST_DT_H;
            end else if (zc) begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered outputs; maxon is delayed one extra stage so it lines up
  // with the hs_en falling edge rather than the HS_ON exit decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_en   <= 1'b0;
      ls_en   <= 1'b0;
      tstate  <= 1'b1;
      maxon_q <= 1'b0;
      maxon   <= 1'b0;
    end else begin
      hs_en   <= hs_c;
      ls_en   <= ls_c;
      tstate  <= ts_c;
      maxon_q <= maxon_hit_c;
      maxon   <= maxon_q;
    end
  end

endmodule
